// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen : parametrised raster timing generator (sync/de/x/y)      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          hblank,
  output logic          vblank,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (CW < 1 || CW > 30 ||
        H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        (longint'(1) << CW) < longint'(c_h_total) ||
        (longint'(1) << CW) < longint'(c_v_total)) begin : g_bad_cfg
      $error("vga_timing_gen: zero width parameter or CW too small for the raster");
    end
  endgenerate

  localparam logic [CW-1:0] c_h_last     = CW'(c_h_total - 1);
  localparam logic [CW-1:0] c_v_last     = CW'(c_v_total - 1);
  localparam logic [CW-1:0] c_h_active   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_active   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          c_hs_on      = (H_POL != 0);
  localparam logic          c_vs_on      = (V_POL != 0);

  logic [CW-1:0] hx_q, hx_d, vy_q, vy_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          h_wrap, h_vis, v_vis, h_in_sync, v_in_sync;

  always_comb begin
    hx_d          = hx_q;
    vy_d          = vy_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    h_wrap        = (hx_q == c_h_last);
    h_vis         = (hx_q < c_h_active);
    v_vis         = (vy_q < c_v_active);
    h_in_sync     = (hx_q >= c_hs_start) && (hx_q < c_hs_end);
    v_in_sync     = (vy_q >= c_vs_start) && (vy_q < c_vs_end);

    // Outputs describe the position held before this advance.
    if (ce) begin
      hx_d = h_wrap ? '0 : hx_q + 1'b1;
      if (h_wrap) begin
        vy_d = (vy_q == c_v_last) ? '0 : vy_q + 1'b1;
      end
      x_d           = hx_q;
      y_d           = vy_q;
      hblank_d      = !h_vis;
      vblank_d      = !v_vis;
      de_d          = h_vis && v_vis;
      hsync_d       = h_in_sync ? c_hs_on : !c_hs_on;
      vsync_d       = v_in_sync ? c_vs_on : !c_vs_on;
      line_start_d  = (hx_q == '0);
      frame_start_d = (hx_q == '0) && (vy_q == '0);
      if (frame_start_d) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hx_q          <= '0;
      vy_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= !c_hs_on;
      vsync_q       <= !c_vs_on;
      de_q          <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      hx_q          <= hx_d;
      vy_q          <= vy_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_timing_gen : scoreboard bench over four raster configurations     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        hb;
    logic        vb;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } out_t;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hp, vp;
  } cfg_t;

  typedef struct {
    out_t o [4];
    int   ph;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  logic        hs0, vs0, de0, hb0, vb0, ls0, fs0;
  logic [9:0]  x0, y0;
  logic [7:0]  fc0;
  logic        hs1, vs1, de1, hb1, vb1, ls1, fs1;
  logic [10:0] x1, y1;
  logic [7:0]  fc1;
  logic        hs2, vs2, de2, hb2, vb2, ls2, fs2;
  logic [2:0]  x2, y2;
  logic [7:0]  fc2;
  logic        hs3, vs3, de3, hb3, vb3, ls3, fs3;
  logic [3:0]  x3, y3;
  logic [7:0]  fc3;

  vga_timing_gen u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs0), .vsync(vs0), .de(de0),
    .hblank(hb0), .vblank(vb0), .x(x0), .y(y0), .line_start(ls0),
    .frame_start(fs0), .frame_cnt(fc0));

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .H_POL(1), .V_POL(1), .CW(11)
  ) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs1), .vsync(vs1), .de(de1),
    .hblank(hb1), .vblank(vb1), .x(x1), .y(y1), .line_start(ls1),
    .frame_start(fs1), .frame_cnt(fc1));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(0), .CW(3)
  ) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs2), .vsync(vs2), .de(de2),
    .hblank(hb2), .vblank(vb2), .x(x2), .y(y2), .line_start(ls2),
    .frame_start(fs2), .frame_cnt(fc2));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .CW(4)
  ) u_dut3 (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs3), .vsync(vs3), .de(de3),
    .hblank(hb3), .vblank(vb3), .x(x3), .y(y3), .line_start(ls3),
    .frame_start(fs3), .frame_cnt(fc3));

  out_t act [4];
  always_comb begin
    act[0] = {11'(x0), 11'(y0), hs0, vs0, de0, hb0, vb0, ls0, fs0, fc0};
    act[1] = {x1, y1, hs1, vs1, de1, hb1, vb1, ls1, fs1, fc1};
    act[2] = {11'(x2), 11'(y2), hs2, vs2, de2, hb2, vb2, ls2, fs2, fc2};
    act[3] = {11'(x3), 11'(y3), hs3, vs3, de3, hb3, vb3, ls3, fs3, fc3};
  end

  cfg_t  cfg [4];
  int    mx [4];
  int    my [4];
  out_t  mo [4];
  exp_t  exp_q [$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic string fmt(input out_t o);
    return $sformatf("x=%0d y=%0d hs=%0b vs=%0b de=%0b hb=%0b vb=%0b ls=%0b fs=%0b fc=%0d",
                     o.x, o.y, o.hs, o.vs, o.de, o.hb, o.vb, o.ls, o.fs, o.fc);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Reference model: advances one clk and queues the expected outputs.
  task automatic step(input bit c, input bit r, input int ph);
    exp_t e;
    int   ht, vt, hs_lo, vs_lo;
    bit   h_in, v_in;
    ce  = c;
    rst = r;
    for (int i = 0; i < 4; i++) begin
      ht    = cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
      vt    = cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp;
      hs_lo = cfg[i].ha + cfg[i].hfp;
      vs_lo = cfg[i].va + cfg[i].vfp;
      if (r) begin
        mo[i]    = '0;
        mo[i].hs = (cfg[i].hp == 0);
        mo[i].vs = (cfg[i].vp == 0);
        mx[i]    = 0;
        my[i]    = 0;
      end else if (c) begin
        h_in     = (mx[i] >= hs_lo) && (mx[i] < hs_lo + cfg[i].hsw);
        v_in     = (my[i] >= vs_lo) && (my[i] < vs_lo + cfg[i].vsw);
        mo[i].x  = 11'(mx[i]);
        mo[i].y  = 11'(my[i]);
        mo[i].hb = (mx[i] >= cfg[i].ha);
        mo[i].vb = (my[i] >= cfg[i].va);
        mo[i].de = (mx[i] < cfg[i].ha) && (my[i] < cfg[i].va);
        mo[i].hs = h_in ? (cfg[i].hp != 0) : (cfg[i].hp == 0);
        mo[i].vs = v_in ? (cfg[i].vp != 0) : (cfg[i].vp == 0);
        mo[i].ls = (mx[i] == 0);
        mo[i].fs = (mx[i] == 0) && (my[i] == 0);
        if (mo[i].fs) mo[i].fc = mo[i].fc + 8'd1;
        mx[i]++;
        if (mx[i] == ht) begin
          mx[i] = 0;
          my[i]++;
          if (my[i] == vt) my[i] = 0;
        end
      end else begin
        mo[i].ls = 1'b0;
        mo[i].fs = 1'b0;
      end
      e.o[i] = mo[i];
    end
    e.ph = ph;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare plus hand-derived timing measurements.
  initial begin
    exp_t e;
    int   len0 = 0, hsl0 = 0, de0n = 0;
    bit   seen0 = 0;
    int   cnt1 = 0, first1 = -1;
    int   nfs2 = 0, px2 = 0, py2 = 0;
    int   vsh3 = 0;
    bit   seen3 = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (act[i] === e.o[i]) n_pass++;
          else $display("FAIL dut%0d ph%0d: got %s | expected %s",
                        i, e.ph, fmt(act[i]), fmt(e.o[i]));
        end
        if (e.ph == 2) begin
          if (act[0].ls) begin
            if (seen0) begin
              chk("line_period", len0, 800);
              chk("hsync_low_clks", hsl0, 96);
              chk("de_clks_per_line", de0n, 640);
            end
            seen0 = 1;
            len0  = 0;
            hsl0  = 0;
            de0n  = 0;
          end
          len0++;
          if (!act[0].hs) hsl0++;
          if (act[0].de) de0n++;
          if (act[1].y == 11'd0 && act[1].hs) begin
            cnt1++;
            if (first1 < 0) first1 = int'(act[1].x);
          end
          if (act[1].ls && act[1].y == 11'd1) begin
            chk("svga_hsync_high_clks", cnt1, 128);
            chk("svga_hsync_first_x", first1, 840);
          end
          if (act[3].fs) begin
            if (seen3) chk("pol1_vsync_high_clks", vsh3, 16);
            seen3 = 1;
            vsh3  = 0;
          end
          if (act[3].vs) vsh3++;
        end
        if ((e.ph == 2 || e.ph == 3) && act[0].fs) begin
          chk("first_frame_cnt", int'(act[0].fc), 1);
        end
        if (e.ph == 4) begin
          if (act[2].fs) begin
            nfs2++;
            if (nfs2 > 1) begin
              chk("wrap_prev_x", px2, 6);
              chk("wrap_prev_y", py2, 4);
            end
            if (nfs2 == 255) chk("frame_cnt_255", int'(act[2].fc), 255);
            if (nfs2 == 256) chk("frame_cnt_wrap", int'(act[2].fc), 0);
          end
          px2 = int'(act[2].x);
          py2 = int'(act[2].y);
        end
      end
    end
  end

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
    cfg[1] = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1};
    cfg[2] = '{4, 1, 1, 1, 2, 1, 1, 1, 0, 0};
    cfg[3] = '{4, 1, 2, 1, 3, 1, 2, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0;
      my[i] = 0;
      mo[i] = '0;
    end

    step(0, 1, 1);
    step(1, 1, 1);
    for (int n = 0; n < 1700; n++) step(1, 0, 2);
    step(1, 1, 3);
    for (int n = 0; n < 900; n++) begin
      step(1, 0, 3);
      step(0, 0, 3);
      step(0, 0, 3);
    end
    step(0, 1, 4);
    for (int n = 0; n < 8970; n++) step(1, 0, 4);
    step(0, 0, 5);
    step(0, 0, 5);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
